seg_shift_rx: RTL

Serial-frame receiver for the segment/LED shift-register protocol that the board display driver produces on its `*_clk` / `*_do` / `*_pen` / `*_clr` pins. It oversamples the four serial lines in the system clock domain, reassembles each WIDTH-bit frame and presents it as a parallel word with a valid/ack handshake. It sits beside the display driver in the SoC for loopback self-test and bench checking of display traffic, and can also capture frames from an external board.

---
 rtl/seg_shift_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seg_shift_rx.sv
// rtl/seg_shift_rx.sv - serial segment/LED frame receiver with valid/ack handshake
//
// Oversamples the display driver's serial lines in the clk domain, rebuilds
// each WIDTH-bit frame (first-shifted bit lands in the MSB) and presents it
// as a parallel word.
//
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   ser_clk, ser_do  serial shift clock / data (asynchronous to clk)
//   ser_pen          latch strobe, rising edge ends a frame
//   ser_clr_n        active-low shift-register clear
//   frame_ack        consumer accepts frame_data
//   frame_data       last good frame
//   frame_valid      sticky, frame_data not yet acknowledged
//   frame_error      one-cycle pulse on a bad-length frame
//   overrun          one-cycle pulse when an unacked frame is replaced
//   busy             partial frame held
//   frame_count      good-frame counter, wraps
module seg_shift_rx #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ser_clk,
  input  logic             ser_do,
  input  logic             ser_pen,
  input  logic             ser_clr_n,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             overrun,
  output logic             busy,
  output logic [15:0]      frame_count
);

  // Count must reach WIDTH+1 so an over-long frame is distinguishable.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] C_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] C_SAT  = CW'(WIDTH + 1);

  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_pen_s1, r_pen_s2, r_pen_prev;
  logic             r_do_s1, r_do_s2;
  logic             r_clr_s1, r_clr_s2;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;

  logic             w_shift;
  logic             w_latch;
  logic             w_clr;
  logic             w_good;
  logic [WIDTH-1:0] w_sr_next;
  logic [CW-1:0]    w_cnt_next;

  assign w_shift = r_clk_s2 & ~r_clk_prev;
  assign w_latch = r_pen_s2 & ~r_pen_prev;
  assign w_clr   = ~r_clr_s2;

  // Shift is resolved first so a latch in the same cycle sees the new bit;
  // clear overrides both.
  always_comb begin
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    if (w_clr) begin
      w_sr_next  = '0;
      w_cnt_next = '0;
    end else if (w_shift) begin
      w_sr_next = {r_sr[WIDTH-2:0], r_do_s2};
      if (r_cnt != C_SAT) begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  assign w_good = w_latch & (w_cnt_next == C_FULL);
  assign busy   = (r_cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_s1    <= 1'b0;
      r_clk_s2    <= 1'b0;
      r_clk_prev  <= 1'b0;
      r_pen_s1    <= 1'b0;
      r_pen_s2    <= 1'b0;
      r_pen_prev  <= 1'b0;
      r_do_s1     <= 1'b0;
      r_do_s2     <= 1'b0;
      r_clr_s1    <= 1'b1;
      r_clr_s2    <= 1'b1;
      r_sr        <= '0;
      r_cnt       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      r_clk_s1   <= ser_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_pen_s1   <= ser_pen;
      r_pen_s2   <= r_pen_s1;
      r_pen_prev <= r_pen_s2;
      r_do_s1    <= ser_do;
      r_do_s2    <= r_do_s1;
      r_clr_s1   <= ser_clr_n;
      r_clr_s2   <= r_clr_s1;

      r_sr  <= w_sr_next;
      r_cnt <= w_latch ? '0 : w_cnt_next;

      frame_error <= w_latch & ~w_good;
      // A same-cycle ack consumes the old frame, so no overrun then.
      overrun     <= w_good & frame_valid & ~frame_ack;

      if (w_good) begin
        frame_data  <= w_sr_next;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
